// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the CPU core. This package also holds the
// memory-stage controller's state encoding and its default abort limit.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Memory-stage control bits carried by the ID/EX and EX/MEM latches.
  typedef struct packed {
    logic dren;
    logic dwen;
    logic halt;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_DREQ   = 2'd1,
    DMEM_DONE   = 2'd2,
    DMEM_HALTED = 2'd3
  } dmem_state_t;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

  function automatic logic is_data_req(input logic dren, input logic dwen);
    return dren | dwen;
  endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Saturating wait counter with synchronous clear/enable and a terminal-count flag.
// Clear has priority over enable.
module dmem_wait_cnt #(
  parameter int CNT_W = 8,
  parameter int TERM  = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERM_C);

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage request controller: holds a data request until dhit, returns
// load data, arbitrates the shared port against fetch, and owns the sticky halt.
module dmem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_in,
  input  logic              halt_in,
  input  logic              iREN_req,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              imemREN,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              mem_stall,
  output logic              halt_out,
  output logic              mem_err
);

  localparam logic TO_EN = (TIMEOUT != 0);

  dmem_state_t       state_q;
  logic              ren_q;
  logic              wen_q;
  logic              is_wr_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] load_data_q;
  logic              load_valid_q;
  logic              halt_q;
  logic              err_q;

  logic req_s;
  logic cnt_clr_s;
  logic cnt_en_s;
  logic cnt_tc_s;
  logic timeout_s;
  logic mem_stall_s;
  logic imem_ren_s;

  assign req_s     = is_data_req(dREN_in, dWEN_in);
  assign cnt_clr_s = (state_q == DMEM_IDLE) && !halt_in && req_s;
  assign cnt_en_s  = (state_q == DMEM_DREQ);
  assign timeout_s = TO_EN && cnt_tc_s;

  dmem_wait_cnt #(
    .CNT_W (CNT_W),
    .TERM  (TIMEOUT)
  ) u_wait_cnt (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .tc_o   (cnt_tc_s)
  );

  // controller FSM with registered request, result and status outputs
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= DMEM_IDLE;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      is_wr_q      <= 1'b0;
      addr_q       <= {DATA_W{1'b0}};
      store_q      <= {DATA_W{1'b0}};
      load_data_q  <= {DATA_W{1'b0}};
      load_valid_q <= 1'b0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          load_valid_q <= 1'b0;
          if (halt_in) begin
            halt_q  <= 1'b1;
            state_q <= DMEM_HALTED;
          end else if (req_s) begin
            // a simultaneous read and write resolves to the write
            addr_q  <= addr_in;
            store_q <= store_in;
            is_wr_q <= dWEN_in;
            wen_q   <= dWEN_in;
            ren_q   <= !dWEN_in;
            state_q <= DMEM_DREQ;
          end else begin
            state_q <= DMEM_IDLE;
          end
        end
        DMEM_DREQ: begin
          if (dhit) begin
            if (!is_wr_q) begin
              load_data_q <= dmemload;
            end
            load_valid_q <= !is_wr_q;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            state_q      <= DMEM_DONE;
          end else if (timeout_s) begin
            err_q        <= 1'b1;
            load_data_q  <= {DATA_W{1'b0}};
            load_valid_q <= !is_wr_q;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            state_q      <= DMEM_DONE;
          end else begin
            state_q <= DMEM_DREQ;
          end
        end
        DMEM_DONE: begin
          load_valid_q <= 1'b0;
          state_q      <= DMEM_IDLE;
        end
        DMEM_HALTED: begin
          ren_q        <= 1'b0;
          wen_q        <= 1'b0;
          load_valid_q <= 1'b0;
          halt_q       <= 1'b1;
          state_q      <= DMEM_HALTED;
        end
        default: begin
          ren_q        <= 1'b0;
          wen_q        <= 1'b0;
          load_valid_q <= 1'b0;
          state_q      <= DMEM_IDLE;
        end
      endcase
    end
  end

  // stall must act in the request cycle itself; fetch only gets an idle port
  always_comb begin
    mem_stall_s = 1'b0;
    imem_ren_s  = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        mem_stall_s = req_s;
        if (req_s || halt_in) begin
          imem_ren_s = 1'b0;
        end else begin
          imem_ren_s = iREN_req;
        end
      end
      DMEM_DREQ: begin
        mem_stall_s = 1'b1;
        imem_ren_s  = 1'b0;
      end
      DMEM_DONE: begin
        mem_stall_s = 1'b0;
        imem_ren_s  = iREN_req;
      end
      DMEM_HALTED: begin
        mem_stall_s = 1'b0;
        imem_ren_s  = 1'b0;
      end
      default: begin
        mem_stall_s = 1'b0;
        imem_ren_s  = 1'b0;
      end
    endcase
  end

  assign dmemREN    = ren_q;
  assign dmemWEN    = wen_q;
  assign dmemaddr   = addr_q;
  assign dmemstore  = store_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign halt_out   = halt_q;
  assign mem_err    = err_q;
  assign mem_stall  = mem_stall_s;
  assign imemREN    = imem_ren_s;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Memory-stage request controller. It consumes the dREN/dWEN/HALT control that the ID/EX and EX/MEM pipeline latches carry, and turns it into a held data-memory request.
- Freezes the pipeline until dhit, returns load data, and gives data accesses priority over instruction fetch on the shared memory port.
- Owns the sticky halt that stops all memory traffic.

Parameters:
- DATA_W, 32, address/data width.
- TIMEOUT, 255, max DREQ cycles before abort; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- dREN_in  in  1  load request from EX/MEM latch
- dWEN_in  in  1  store request from EX/MEM latch
- addr_in  in  DATA_W  effective address
- store_in  in  DATA_W  store data
- halt_in  in  1  HALT reached memory stage
- iREN_req  in  1  fetch wants instruction
- dhit  in  1  data access complete
- dmemload  in  DATA_W  read data from cache
- dmemREN  out  1  data read enable
- dmemWEN  out  1  data write enable
- dmemaddr  out  DATA_W  data address
- dmemstore  out  DATA_W  data to store
- imemREN  out  1  instruction read enable
- load_data  out  DATA_W  captured load result
- load_valid  out  1  load_data valid (one cycle)
- mem_stall  out  1  freeze all pipeline latches
- halt_out  out  1  sticky halt
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: sampled on posedge CLK with nRST=0; applies mid-operation too, and any dhit in that cycle is ignored. All outputs go to 0, state goes to IDLE, counter clears.
- States: IDLE, DREQ, DONE, HALTED. All outputs are registered except mem_stall and imemREN.
- IDLE:
  - halt_in=1 → HALTED. Halt has priority over a simultaneous dREN/dWEN; no request is issued.
  - Else dREN_in|dWEN_in → capture addr_in/store_in and op type → DREQ. If both are set, the write wins and the read is dropped.
  - mem_stall = dREN_in|dWEN_in, combinational, so the pipeline holds the same cycle.
- DREQ:
  - dmemREN/dmemWEN (exactly one) plus dmemaddr/dmemstore are held stable from the first DREQ cycle until the cycle dhit is seen.
  - mem_stall=1. Counter increments each cycle.
  - dhit → for a read, load_data<=dmemload; then → DONE; enables deassert on the transition.
  - counter==TIMEOUT with TIMEOUT≠0 and no dhit → mem_err<=1, load_data<=0, → DONE.
  - halt_in is ignored in DREQ.
- DONE:
  - Lasts exactly one cycle. mem_stall=0. load_valid=1 only if the op was a read.
  - Request inputs are ignored, since they still describe the completed op. → IDLE.
  - load_data holds its value until the next read completes.
- HALTED:
  - Terminal until reset. halt_out=1. All memory enables are 0, including imemREN. mem_stall=0.
- imemREN:
  - = iREN_req && state∈{IDLE, DONE} && !(state==IDLE && (dREN_in|dWEN_in|halt_in)).
  - The data side always wins the port.
- Latency: request cycle → dmemREN is visible 1 cycle later. A 1-cycle dhit gives a minimum 3-cycle load (IDLE, DREQ, DONE).
- Counter clears on every entry to DREQ and saturates at 2^CNT_W−1.

Decomposition:
- dmem_state_t enum (IDLE, DREQ, DONE, HALTED) and the default TIMEOUT constant go in cpu_types_pkg alongside the existing pipeline types.
- One sub-module is natural: dmem_wait_cnt. It is a parameterised saturating counter with clear/enable and a terminal-count output, and is reused by future cache wait logic.
- The FSM and request holding registers stay in dmem_ctrl.

Test Plan:
- Load, dhit after 3 cycles: dREN_in=1, addr_in=0x0000_0040, dmemload=0xDEAD_BEEF.
  → dmemREN=1 for 3 cycles with dmemaddr=0x40 stable. mem_stall=1 from cycle 0 through the dhit cycle. load_valid=1 for exactly one cycle with load_data=0xDEADBEEF. imemREN=0 throughout DREQ.
- Store plus fetch contention: dWEN_in=1, addr=0x80, store=0x1234, iREN_req=1, dhit on the first DREQ cycle.
  → dmemWEN=1 for one cycle, dmemstore=0x1234, imemREN=0 until DONE, then 1. load_valid stays 0.
- Simultaneous halt_in=1 and dREN_in=1 in IDLE.
  → next cycle halt_out=1, dmemREN never asserts. Later dREN_in=1 and iREN_req=1 give no enables, mem_stall=0.
- TIMEOUT=4, dREN_in=1, dhit held 0.
  → dmemREN high for 5 DREQ cycles, then mem_err=1, load_data=0, load_valid pulse. mem_err stays 1 across later successful loads.
- Reset mid-DREQ: drive nRST=0 for one edge on DREQ cycle 2 with dhit=1.
  → all outputs 0 after the edge, state IDLE, load_valid never pulses, mem_err=0.
- dREN_in=dWEN_in=1, addr=0x10.
  → only dmemWEN asserts. Back-to-back: a new request held in DONE is ignored and is accepted from IDLE on the following cycle.
